// File: rtl/lowf_q_pkg.sv
// Shared types and sizing helpers for the low-frequency window queue.
package lowf_q_pkg;

  typedef enum logic [1:0] {
    StFill,
    StReady,
    StSeq
  } state_e;

  // Address width for a power-of-two ring; never narrower than one bit.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/lowf_window_queue_if.sv
// Sample-in / window-out signal bundle of the low-frequency window queue.
interface lowf_window_queue_if #(
  parameter int unsigned DATA_W = 16
);
  logic [DATA_W-1:0] new_smpl;
  logic              wrt_smpl;
  logic [DATA_W-1:0] smpl_out;
  logic              smpl_vld;
  logic              sequencing;
  logic              seq_last;
  logic              full;
  logic              overrun;

  modport master (
    output new_smpl, wrt_smpl,
    input  smpl_out, smpl_vld, sequencing, seq_last, full, overrun
  );

  modport slave (
    input  new_smpl, wrt_smpl,
    output smpl_out, smpl_vld, sequencing, seq_last, full, overrun
  );
endinterface

// File: rtl/dual_port_ram.sv
// Simple dual-port RAM: one write port, one registered read port on the same clock.
module dual_port_ram
  import lowf_q_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 1024,
  localparam int unsigned AW    = ptr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read register holds its value between reads so the output is stable when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end
endmodule

// File: rtl/lowf_window_queue.sv
// Decimating sample ring that replays the newest WINDOW samples, oldest first, after each
// accepted sample once the ring has been primed.
module lowf_window_queue
  import lowf_q_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned WINDOW = 1021,
  parameter int unsigned DECIM  = 2
) (
  input logic                clk,
  input logic                rst_n,
  lowf_window_queue_if.slave q
);
  localparam int unsigned PtrW = ptr_w(DEPTH);
  localparam int unsigned CntW = $clog2(WINDOW + 1);
  localparam int unsigned DecW = ptr_w(DECIM);

  state_e            state_q, state_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   beat_q, beat_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DecW-1:0]   dec_q, dec_d;
  logic              pend_q, pend_d;
  logic              ovr_q, ovr_d;
  logic              vld_q, last_q;
  logic              accept, start_req, last_addr;
  logic [DATA_W-1:0] rd_data;

  assign accept    = q.wrt_smpl && (dec_q == '0);
  // Covers both the write that completes the fill and any write once already full.
  assign start_req = accept && (cnt_q >= CntW'(WINDOW - 1));
  assign last_addr = (state_q == StSeq) && (beat_q == PtrW'(WINDOW - 1));

  always_comb begin
    dec_d    = dec_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (q.wrt_smpl) dec_d = (dec_q == DecW'(DECIM - 1)) ? '0 : dec_q + 1'b1;
    if (accept) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (cnt_q != CntW'(WINDOW)) cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    beat_d   = beat_q;
    pend_d   = pend_q;
    ovr_d    = ovr_q;
    case (state_q)
      StFill, StReady: begin
        if (start_req) begin
          state_d  = StSeq;
          rd_ptr_d = wr_ptr_d - PtrW'(WINDOW);
          beat_d   = '0;
        end
      end
      StSeq: begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        beat_d   = beat_q + 1'b1;
        if (start_req) begin
          if (pend_q) ovr_d = 1'b1;
          else        pend_d = 1'b1;
        end
        if (last_addr) begin
          pend_d = 1'b0;
          // Restart immediately so the next window follows with no idle beat.
          if (pend_q || start_req) begin
            rd_ptr_d = wr_ptr_d - PtrW'(WINDOW);
            beat_d   = '0;
          end else begin
            state_d = StReady;
          end
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StFill;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      beat_q   <= '0;
      cnt_q    <= '0;
      dec_q    <= '0;
      pend_q   <= 1'b0;
      ovr_q    <= 1'b0;
      vld_q    <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      beat_q   <= beat_d;
      cnt_q    <= cnt_d;
      dec_q    <= dec_d;
      pend_q   <= pend_d;
      ovr_q    <= ovr_d;
      vld_q    <= (state_q == StSeq);
      last_q   <= last_addr;
    end
  end

  dual_port_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (accept),
    .wr_addr (wr_ptr_q),
    .wr_data (q.new_smpl),
    .rd_en   (state_q == StSeq),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

  assign q.smpl_out   = rd_data;
  assign q.smpl_vld   = vld_q;
  assign q.seq_last   = last_q;
  assign q.sequencing = (state_q == StSeq) || last_q;
  assign q.full       = (cnt_q == CntW'(WINDOW));
  assign q.overrun    = ovr_q;
endmodule

// File: tb/tb_lowf_window_queue.sv
// Bench for lowf_window_queue: two instances (decimating and non-decimating) against a
// sample-history reference model that schedules expected window beats per clock.
module tb_lowf_window_queue;
  localparam int Slots = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lowf_window_queue_if #(.DATA_W(16)) qa ();
  lowf_window_queue_if #(.DATA_W(16)) qb ();

  lowf_window_queue #(.DATA_W(16), .DEPTH(16), .WINDOW(12), .DECIM(2)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (qa)
  );

  lowf_window_queue #(.DATA_W(16), .DEPTH(32), .WINDOW(15), .DECIM(1)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (qb)
  );

  // Reference model: history of accepted samples plus per-cycle expected outputs.
  int          win [2] = '{12, 15};
  int          dec [2] = '{2, 1};
  int          nstr [2], cnt [2], busy [2], nacc [2];
  bit          pend [2], ovr [2];
  logic [15:0] hist [2][Slots];
  bit          xv [2][Slots], xl [2][Slots], xs [2][Slots];
  logic [15:0] xd [2][Slots];
  int          s = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic int slot(int t);
    return t % Slots;
  endfunction

  function automatic logic [4:0] m_flags(int u);
    int k;
    k = slot(s);
    return {xv[u][k], xl[u][k], xs[u][k], cnt[u] == win[u], ovr[u]};
  endfunction

  task automatic m_reset(int u);
    cnt[u] = 0; nstr[u] = 0; busy[u] = 0; pend[u] = 0; ovr[u] = 0;
    for (int i = 0; i < Slots; i++) begin
      xv[u][i] = 0; xl[u][i] = 0; xs[u][i] = 0;
    end
  endtask

  // A window is the newest win[u] accepted samples; beats land on the next win[u] cycles.
  task automatic m_start(int u);
    for (int i = 0; i <= win[u]; i++) xs[u][slot(s + i)] = 1;
    for (int i = 0; i < win[u]; i++) begin
      xv[u][slot(s + 1 + i)] = 1;
      xd[u][slot(s + 1 + i)] = hist[u][(nacc[u] - win[u] + i) % Slots];
      xl[u][slot(s + 1 + i)] = (i == win[u] - 1);
    end
    busy[u] = win[u];
  endtask

  task automatic m_step(int u, bit wr, logic [15:0] d);
    bit acc, req;
    xv[u][slot(s - 1)] = 0; xl[u][slot(s - 1)] = 0; xs[u][slot(s - 1)] = 0;
    acc = wr && (nstr[u] % dec[u] == 0);
    if (wr) nstr[u]++;
    if (acc) begin
      hist[u][nacc[u] % Slots] = d;
      nacc[u]++;
      if (cnt[u] < win[u]) cnt[u]++;
    end
    req = acc && (cnt[u] == win[u]);
    if (busy[u] > 0) begin
      if (req) begin
        if (pend[u]) ovr[u] = 1;
        else         pend[u] = 1;
      end
      busy[u]--;
      if (busy[u] == 0 && pend[u]) begin
        pend[u] = 0;
        m_start(u);
      end
    end else if (req) begin
      m_start(u);
    end
  endtask

  task automatic drive(int u, bit wr, logic [15:0] d);
    if (u == 0) begin
      qa.wrt_smpl = wr; qa.new_smpl = d;
    end else begin
      qb.wrt_smpl = wr; qb.new_smpl = d;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    s++;
    if (!rst_n) begin
      m_reset(0); m_reset(1);
    end else begin
      m_step(0, qa.wrt_smpl, qa.new_smpl);
      m_step(1, qb.wrt_smpl, qb.new_smpl);
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    m_reset(0); m_reset(1);
    tick(); tick();
    n_cmp++;
    if ({qa.smpl_vld, qa.seq_last, qa.sequencing, qa.full, qa.overrun, qa.smpl_out} !== 21'd0) begin
      n_bad++;
      $display("FAIL reset_a outputs got %b %h want all zero",
               {qa.smpl_vld, qa.seq_last, qa.sequencing, qa.full, qa.overrun}, qa.smpl_out);
    end
    n_cmp++;
    if ({qb.smpl_vld, qb.seq_last, qb.sequencing, qb.full, qb.overrun, qb.smpl_out} !== 21'd0) begin
      n_bad++;
      $display("FAIL reset_b outputs got %b %h want all zero",
               {qb.smpl_vld, qb.seq_last, qb.sequencing, qb.full, qb.overrun}, qb.smpl_out);
    end
    rst_n = 1'b1;
  endtask

  // 23 strobes, every second one accepted: the 12th accepted (0x17) triggers the first window.
  task automatic test_fill_first();
    logic [15:0] got [$];
    logic [15:0] last_v = '0;
    bit          saw_last = 0;
    for (int i = 1; i <= 39; i++) begin
      drive(0, i <= 23, (i <= 23) ? 16'(i) : 16'h0);
      tick();
      n_cmp++;
      if ({qa.smpl_vld, qa.seq_last, qa.sequencing, qa.full, qa.overrun} !== m_flags(0) ||
          (xv[0][slot(s)] && qa.smpl_out !== xd[0][slot(s)])) begin
        n_bad++;
        $display("FAIL fill_stream step %0d flags %b data %h want flags %b data %h", s,
                 {qa.smpl_vld, qa.seq_last, qa.sequencing, qa.full, qa.overrun}, qa.smpl_out,
                 m_flags(0), xd[0][slot(s)]);
      end
      if (qa.smpl_vld) got.push_back(qa.smpl_out);
      if (qa.seq_last) begin
        saw_last = 1; last_v = qa.smpl_out;
      end
    end
    n_cmp++;
    if (got.size() != 12) begin
      n_bad++;
      $display("FAIL fill_beats got %0d want 12", got.size());
    end
    for (int k = 0; k < got.size() && k < 12; k++) begin
      n_cmp++;
      if (got[k] !== 16'(2 * k + 1)) begin
        n_bad++;
        $display("FAIL fill_order beat %0d got %h want %h", k, got[k], 16'(2 * k + 1));
      end
    end
    n_cmp++;
    if (!saw_last || last_v !== 16'h0017) begin
      n_bad++;
      $display("FAIL fill_last got %b/%h want 1/0017", saw_last, last_v);
    end
    n_cmp++;
    if (qa.full !== 1'b1) begin
      n_bad++;
      $display("FAIL fill_full got %b want 1", qa.full);
    end
  endtask

  // 0x18 is decimated away, 0x19 is accepted and replays 0x03..0x19.
  task automatic test_second_window();
    logic [15:0] got [$];
    for (int i = 0; i < 18; i++) begin
      drive(0, i < 2, (i == 0) ? 16'h0018 : 16'h0019);
      tick();
      n_cmp++;
      if ({qa.smpl_vld, qa.seq_last, qa.sequencing, qa.full, qa.overrun} !== m_flags(0) ||
          (xv[0][slot(s)] && qa.smpl_out !== xd[0][slot(s)])) begin
        n_bad++;
        $display("FAIL second_stream step %0d flags %b data %h want flags %b data %h", s,
                 {qa.smpl_vld, qa.seq_last, qa.sequencing, qa.full, qa.overrun}, qa.smpl_out,
                 m_flags(0), xd[0][slot(s)]);
      end
      if (qa.smpl_vld) got.push_back(qa.smpl_out);
    end
    n_cmp++;
    if (got.size() != 12) begin
      n_bad++;
      $display("FAIL second_beats got %0d want 12", got.size());
    end
    for (int k = 0; k < got.size() && k < 12; k++) begin
      n_cmp++;
      if (got[k] !== 16'(2 * k + 3)) begin
        n_bad++;
        $display("FAIL second_order beat %0d got %h want %h", k, got[k], 16'(2 * k + 3));
      end
    end
  endtask

  // Strobe every clock: pending starts chain windows back to back, the extra ones overrun.
  task automatic test_back_to_back();
    bit rose = 0;
    int gaps = 0;
    for (int i = 0; i < 72; i++) begin
      drive(0, i < 40, 16'($urandom));
      tick();
      n_cmp++;
      if ({qa.smpl_vld, qa.seq_last, qa.sequencing, qa.full, qa.overrun} !== m_flags(0) ||
          (xv[0][slot(s)] && qa.smpl_out !== xd[0][slot(s)])) begin
        n_bad++;
        $display("FAIL b2b_stream step %0d flags %b data %h want flags %b data %h", s,
                 {qa.smpl_vld, qa.seq_last, qa.sequencing, qa.full, qa.overrun}, qa.smpl_out,
                 m_flags(0), xd[0][slot(s)]);
      end
      if (qa.sequencing) rose = 1;
      else if (rose && i < 40) gaps++;
    end
    n_cmp++;
    if (!rose || gaps != 0) begin
      n_bad++;
      $display("FAIL b2b_continuous rose %b gaps %0d want 1 0", rose, gaps);
    end
    n_cmp++;
    if (qa.overrun !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_overrun got %b want 1", qa.overrun);
    end
    n_cmp++;
    if (qa.sequencing !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_drain sequencing got %b want 0", qa.sequencing);
    end
  endtask

  task automatic test_reset_mid();
    int beats = 0;
    int seen = 0;
    int guard;
    for (guard = 0; guard < 8 && !qa.sequencing; guard++) begin
      drive(0, 1'b1, 16'($urandom));
      tick();
    end
    drive(0, 1'b0, '0);
    n_cmp++;
    if (qa.sequencing !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_start sequencing got %b want 1 within 8 cycles", qa.sequencing);
    end
    for (guard = 0; guard < 20 && beats < 5; guard++) begin
      tick();
      n_cmp++;
      if ({qa.smpl_vld, qa.seq_last, qa.sequencing, qa.full, qa.overrun} !== m_flags(0) ||
          (xv[0][slot(s)] && qa.smpl_out !== xd[0][slot(s)])) begin
        n_bad++;
        $display("FAIL mid_stream step %0d flags %b data %h want flags %b data %h", s,
                 {qa.smpl_vld, qa.seq_last, qa.sequencing, qa.full, qa.overrun}, qa.smpl_out,
                 m_flags(0), xd[0][slot(s)]);
      end
      if (qa.smpl_vld) beats++;
    end
    n_cmp++;
    if (beats != 5) begin
      n_bad++;
      $display("FAIL mid_beat5 got %0d beats want 5", beats);
    end
    #2;
    rst_n = 1'b0;
    m_reset(0); m_reset(1);
    #1;
    n_cmp++;
    if ({qa.smpl_vld, qa.seq_last, qa.sequencing, qa.full, qa.overrun, qa.smpl_out} !== 21'd0) begin
      n_bad++;
      $display("FAIL mid_abort outputs got %b %h want all zero",
               {qa.smpl_vld, qa.seq_last, qa.sequencing, qa.full, qa.overrun}, qa.smpl_out);
    end
    tick(); tick();
    rst_n = 1'b1;
    // 21 strobes from reset = 11 accepted: one short of a window.
    for (int i = 0; i < 55; i++) begin
      drive(0, (i < 21) || (i == 37) || (i == 38), 16'($urandom));
      tick();
      n_cmp++;
      if ({qa.smpl_vld, qa.seq_last, qa.sequencing, qa.full, qa.overrun} !== m_flags(0) ||
          (xv[0][slot(s)] && qa.smpl_out !== xd[0][slot(s)])) begin
        n_bad++;
        $display("FAIL refill_stream step %0d flags %b data %h want flags %b data %h", s,
                 {qa.smpl_vld, qa.seq_last, qa.sequencing, qa.full, qa.overrun}, qa.smpl_out,
                 m_flags(0), xd[0][slot(s)]);
      end
      if (i < 38 && (qa.smpl_vld || qa.sequencing || qa.full)) seen++;
      if (i >= 38 && qa.smpl_vld) beats++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_bad++;
      $display("FAIL refill_early got %0d active cycles want 0", seen);
    end
    n_cmp++;
    if (beats != 5 + 12) begin
      n_bad++;
      $display("FAIL refill_window got %0d beats want 12", beats - 5);
    end
  endtask

  task automatic test_underfill();
    int seen = 0;
    int gap;
    rst_n = 1'b0;
    m_reset(0); m_reset(1);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 21; i++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g <= gap; g++) begin
        drive(0, g == gap, 16'($urandom));
        tick();
        n_cmp++;
        if ({qa.smpl_vld, qa.seq_last, qa.sequencing, qa.full, qa.overrun} !== m_flags(0)) begin
          n_bad++;
          $display("FAIL under_flags step %0d got %b want %b", s,
                   {qa.smpl_vld, qa.seq_last, qa.sequencing, qa.full, qa.overrun}, m_flags(0));
        end
        if (qa.smpl_vld || qa.sequencing || qa.full) seen++;
      end
    end
    drive(0, 1'b0, '0);
    for (int i = 0; i < 16; i++) begin
      tick();
      if (qa.smpl_vld || qa.sequencing || qa.full) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_bad++;
      $display("FAIL under_active got %0d active cycles want 0", seen);
    end
  endtask

  // Non-decimating instance with random strobe gaps.
  task automatic test_decim1();
    int strobes = 0;
    int first = -1;
    int beats = 0;
    int exp_beats = 0;
    int gap;
    for (int i = 0; i < 140; i++) begin
      gap = (i < 100) ? $urandom_range(0, 3) : 0;
      for (int g = 0; g <= gap; g++) begin
        drive(1, (i < 100) && (g == gap), 16'($urandom));
        if (i < 100 && g == gap) strobes++;
        tick();
        n_cmp++;
        if ({qb.smpl_vld, qb.seq_last, qb.sequencing, qb.full, qb.overrun} !== m_flags(1) ||
            (xv[1][slot(s)] && qb.smpl_out !== xd[1][slot(s)])) begin
          n_bad++;
          $display("FAIL decim1_stream step %0d flags %b data %h want flags %b data %h", s,
                   {qb.smpl_vld, qb.seq_last, qb.sequencing, qb.full, qb.overrun}, qb.smpl_out,
                   m_flags(1), xd[1][slot(s)]);
        end
        if (qb.sequencing && first < 0) first = strobes;
        if (qb.smpl_vld) beats++;
        if (xv[1][slot(s)]) exp_beats++;
      end
    end
    n_cmp++;
    if (first != 15) begin
      n_bad++;
      $display("FAIL decim1_first_window got strobe %0d want 15", first);
    end
    n_cmp++;
    if (beats != exp_beats || beats == 0) begin
      n_bad++;
      $display("FAIL decim1_beats got %0d want %0d", beats, exp_beats);
    end
  endtask

  initial begin
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    test_reset();
    test_fill_first();
    test_second_window();
    test_back_to_back();
    test_reset_mid();
    test_underfill();
    test_decim1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached at step %0d", s);
    $fatal(1, "watchdog");
  end
endmodule
